frame_mem_arbiter: RTL

Arbitrates the single-port 4-bit x 32K frame memory between two requesters. The camera-side pixel writer has no backpressure, so its writes go through a small FIFO. The blob-scan reader uses a req/ack handshake. Writes have priority, and a burst limit guarantees the reader is served. The block sits between frame_array-style producer/consumer logic and the memory instance, and owns rden, wren, address and data.

---
 rtl/frame_mem_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/frame_mem_arbiter.sv
// frame_mem_arbiter: shares the single-port frame memory between a buffered
// pixel writer (no backpressure) and a req/ack blob-scan reader. Writes win
// until they have held off a waiting read for MAX_WR_BURST consecutive grants.
module frame_mem_arbiter #(
  parameter int unsigned ADDR_W       = 15,
  parameter int unsigned DATA_W       = 4,
  parameter int unsigned WBUF_DEPTH   = 4,
  parameter int unsigned MAX_WR_BURST = 8,
  parameter int unsigned RD_LATENCY   = 2
) (
  input  logic                        iClock,
  input  logic                        iReset,
  input  logic                        iWrReq,
  input  logic [ADDR_W-1:0]           iWrAddr,
  input  logic [DATA_W-1:0]           iWrData,
  input  logic                        iRdReq,
  input  logic [ADDR_W-1:0]           iRdAddr,
  output logic                        oRdAck,
  output logic                        oRdValid,
  output logic [DATA_W-1:0]           oRdData,
  output logic [ADDR_W-1:0]           oMemAddr,
  output logic [DATA_W-1:0]           oMemData,
  output logic                        oMemRdEn,
  output logic                        oMemWrEn,
  input  logic [DATA_W-1:0]           iMemQ,
  output logic [$clog2(WBUF_DEPTH):0] oWrLevel,
  output logic                        oOverflow,
  output logic                        oBusy
);

  localparam int unsigned PTR_W    = $clog2(WBUF_DEPTH);
  localparam int unsigned LVL_W    = PTR_W + 1;
  localparam int unsigned STREAK_W = $clog2(MAX_WR_BURST + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_RD   = 2'd2
  } gnt_e;

  wr_entry_t             fifo_mem [WBUF_DEPTH];
  wr_entry_t             head;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [LVL_W-1:0]      level;
  logic [STREAK_W-1:0]   wr_streak;
  logic [RD_LATENCY-1:0] rd_vld;
  logic                  overflow;
  logic [ADDR_W-1:0]     addr_hold;
  logic [DATA_W-1:0]     data_hold;
  gnt_e                  gnt;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  push;
  logic                  pop;

  assign head       = fifo_mem[rd_ptr];
  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LVL_W'(WBUF_DEPTH));
  assign pop        = (gnt == GNT_WR);
  // A full FIFO still accepts a pixel when the head drains in the same cycle.
  assign push       = iWrReq && (!fifo_full || pop);

  // Grant decision: buffered write first, unless a waiting read has hit the burst limit.
  always_comb begin
    gnt = GNT_IDLE;
    if (!iReset) begin
      if (!fifo_empty && (!iRdReq || (wr_streak < STREAK_W'(MAX_WR_BURST)))) begin
        gnt = GNT_WR;
      end else if (iRdReq) begin
        gnt = GNT_RD;
      end
    end
  end

  // Memory-side drive for the granted requester; address/data hold when idle.
  always_comb begin
    oMemWrEn = 1'b0;
    oMemRdEn = 1'b0;
    oRdAck   = 1'b0;
    oMemAddr = addr_hold;
    oMemData = data_hold;
    case (gnt)
      GNT_WR: begin
        oMemWrEn = 1'b1;
        oMemAddr = head.addr;
        oMemData = head.data;
      end
      GNT_RD: begin
        oMemRdEn = 1'b1;
        oRdAck   = 1'b1;
        oMemAddr = iRdAddr;
      end
      default: ;
    endcase
  end

  // Write FIFO storage; stale entries are harmless because pointers are reset.
  always_ff @(posedge iClock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{addr: iWrAddr, data: iWrData};
    end
  end

  // FIFO pointers, occupancy and sticky drop flag.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: ;
      endcase
      if (iWrReq && !push) begin
        overflow <= 1'b1;
      end
    end
  end

  // Consecutive write grants taken while a read waits, saturating at the burst limit.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      wr_streak <= '0;
    end else if (!iRdReq || (gnt == GNT_RD)) begin
      wr_streak <= '0;
    end else if ((gnt == GNT_WR) && (wr_streak < STREAK_W'(MAX_WR_BURST))) begin
      wr_streak <= wr_streak + STREAK_W'(1);
    end
  end

  // Read-return valid pipeline aligned with the memory latency.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      rd_vld <= '0;
    end else begin
      rd_vld[0] <= (gnt == GNT_RD);
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        rd_vld[i] <= rd_vld[i-1];
      end
    end
  end

  // Last driven address/data, held on the memory bus during idle cycles.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      addr_hold <= '0;
      data_hold <= '0;
    end else begin
      addr_hold <= oMemAddr;
      data_hold <= oMemData;
    end
  end

  assign oRdValid  = rd_vld[RD_LATENCY-1];
  assign oRdData   = oRdValid ? iMemQ : '0;
  assign oWrLevel  = level;
  assign oOverflow = overflow;
  assign oBusy     = !fifo_empty || (|rd_vld);

endmodule
